// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
//   UART receive front end for the UART-to-Wishbone bridge. Synchronises the
//   serial line, validates the start bit at mid-bit, samples 8 data bits
//   LSB-first at mid-bit, checks the stop bit, and hands each byte to the
//   command parser through a one-entry valid/ready holding register.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   i_start_rx   receive enable; low aborts any frame and holds IDLE
//   i_uart_rx    asynchronous serial input, idle high
//   o_data       received byte, stable while o_valid=1
//   o_valid      holding register full
//   i_ready      consumer accepts o_data when o_valid & i_ready
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overrun    one-cycle pulse: byte dropped because holding register full
//   o_busy       FSM not in IDLE
module uart_rx_deframer #(
  parameter longint unsigned CLOCK_FREQ   = 50000000,
  parameter longint unsigned BAUD_RATE    = 9600,
  parameter int unsigned     CLKS_PER_BIT = 32'(CLOCK_FREQ / BAUD_RATE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start_rx,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  if (CLKS_PER_BIT < 4) begin : g_cpb_check
    $error("uart_rx_deframer: CLKS_PER_BIT must be >= 4");
  end

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic             sync1_q, sync2_q;
  logic             rx_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             load_ok;
  logic             stop_err;

  assign rx_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    load_ok   = 1'b0;
    stop_err  = 1'b0;
    if (!i_start_rx) begin
      state_d   = S_IDLE;
      clk_cnt_d = '0;
      bit_idx_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d   = S_START;
            clk_cnt_d = '0;
          end
        end
        S_START: begin
          if (clk_cnt_q == CNT_MID) begin
            clk_cnt_d = '0;
            bit_idx_d = '0;
            // Line back high at mid start bit: glitch, no frame.
            state_d   = rx_s ? S_IDLE : S_DATA;
          end else begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_d          = '0;
            shift_d[bit_idx_q] = rx_s;
            if (bit_idx_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_d = '0;
            // Leaving at mid-stop lets the next start edge be caught with no gap.
            if (rx_s) begin
              load_ok = 1'b1;
              state_d = S_IDLE;
            end else begin
              stop_err = 1'b1;
              state_d  = S_BREAK;
            end
          end else begin
            clk_cnt_d = clk_cnt_q + CNT_W'(1);
          end
        end
        S_BREAK: begin
          // A held-low line must go high before another start is accepted.
          if (rx_s) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= S_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= i_uart_rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= stop_err;
      overrun_q   <= 1'b0;
      if (load_ok) begin
        // A consume in the same cycle frees the slot for the new byte.
        if (!valid_q || i_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer
//   Scoreboard bench for uart_rx_deframer at CLKS_PER_BIT=10. The stimulus
//   process queues each byte expected at the consumer before sending it; a
//   negedge monitor pops and compares on every accepted beat, counts error
//   pulses, and checks that a held byte never changes.
module tb_uart_rx_deframer;

  localparam int unsigned CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start_rx;
  logic       i_uart_rx;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  uart_rx_deframer #(
    .CLOCK_FREQ (64'd10_000_000_000),
    .BAUD_RATE  (64'd1_000_000_000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start_rx  (i_start_rx),
    .i_uart_rx   (i_uart_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         fe_seen = 0;
  int         fe_exp = 0;
  int         ov_seen = 0;
  int         ov_exp = 0;
  logic       held = 1'b0;
  logic [7:0] held_data = '0;
  logic [7:0] e_byte;
  logic [7:0] seq [6] = '{8'h11, 8'hBB, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] partial;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic line_bit(input logic v);
    i_uart_rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int unsigned gap_bits);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit(stop_v);
    for (int unsigned g = 0; g < gap_bits; g++) line_bit(1'b1);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      if (o_frame_err) fe_seen++;
      if (o_overrun) ov_seen++;
      if (held && o_valid) chk("hold_stable", {24'd0, o_data}, {24'd0, held_data});
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", o_data);
        end else begin
          e_byte = exp_q.pop_front();
          chk("rx_byte", {24'd0, o_data}, {24'd0, e_byte});
        end
      end
      held      = o_valid && !i_ready;
      held_data = o_data;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    i_start_rx = 1'b1;
    i_uart_rx  = 1'b1;
    i_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_frame_err", o_frame_err, 0);
    chk("rst_overrun", o_overrun, 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Single byte
    exp_q.push_back(8'hFF);
    send_frame(8'hFF, 1'b1, 2);
    chk("busy_after_ff", o_busy, 0);

    // Back-to-back with one idle bit
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(seq[i]);
      send_frame(seq[i], 1'b1, 1);
    end
    line_bit(1'b1);
    chk("seq_fe_none", fe_seen, 0);

    // Short glitch on the line
    i_uart_rx = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_uart_rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("glitch_idle", o_busy, 0);
    chk("glitch_fe_none", fe_seen, 0);

    // Framing error followed by a break
    fe_exp++;
    send_frame(8'h55, 1'b0, 0);
    i_uart_rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("break_busy", o_busy, 1);
    chk("break_fe_once", fe_seen, 1);
    i_uart_rx = 1'b1;
    line_bit(1'b1);
    line_bit(1'b1);
    chk("break_released", o_busy, 0);
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1, 2);

    // Overrun with the consumer stalled
    i_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1);
    ov_exp++;
    send_frame(8'h3C, 1'b1, 2);
    chk("ovr_valid", o_valid, 1);
    chk("ovr_data", o_data, 8'hA5);
    chk("ovr_count", ov_seen, 1);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_drained", o_valid, 0);

    // Reset mid-frame with a byte held
    i_ready = 1'b0;
    send_frame(8'h99, 1'b1, 1);
    chk("held_99", o_valid, 1);
    partial = 8'hC3;
    line_bit(1'b0);
    for (int i = 0; i < 4; i++) line_bit(partial[i]);
    i_uart_rx = partial[4];
    repeat (5) @(posedge clk);
    #1;
    rst       = 1'b1;
    i_uart_rx = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_frame_err", o_frame_err, 0);
    chk("mid_rst_overrun", o_overrun, 0);
    rst     = 1'b0;
    i_ready = 1'b1;
    line_bit(1'b1);
    line_bit(1'b1);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 2);

    for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("fe_total", fe_seen, fe_exp);
    chk("ov_total", ov_seen, ov_exp);
    chk("final_busy", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Serial receive front end that feeds the UART-to-Wishbone bridge.
- Synchronises the asynchronous RX line and detects and validates the start bit.
- Samples 8 data bits LSB-first at mid-bit and checks the stop bit.
- Delivers each byte to the bridge command parser through a one-entry valid/ready holding register, with framing-error and overrun reporting.

Parameters:
- CLOCK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate in baud.
- CLKS_PER_BIT, CLOCK_FREQ/BAUD_RATE (integer), clocks per bit; must be >= 4, enforced by an elaboration-time check.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- i_start_rx  input  1  receive enable; low aborts any frame in progress and holds the FSM in IDLE.
- i_uart_rx  input  1  asynchronous serial line, idle high.
- o_data  output  8  received byte, stable while o_valid=1.
- o_valid  output  1  holding register full.
- i_ready  input  1  consumer accepts o_data on a cycle where o_valid & i_ready.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- o_overrun  output  1  one-cycle pulse: a byte completed while the holding register was full and not being consumed.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0, FSM=IDLE, both synchroniser flops=1, counters=0. Reset mid-frame discards the partial byte and drops any held byte.
- Synchroniser: 2 flops on i_uart_rx. All decisions use the second flop (rx_s). Input-to-rx_s latency is 2 cycles.
- Bit counter: clk_cnt counts 0..CLKS_PER_BIT-1. bit_idx counts 0..7.
- IDLE:
  - If i_start_rx=1 and rx_s=0: go to START, clk_cnt=0.
- START:
  - When clk_cnt reaches CLKS_PER_BIT/2-1 (mid start bit): if rx_s=0, go to DATA with clk_cnt=0 and bit_idx=0.
  - If rx_s=1 at that point, treat as a glitch: return to IDLE with no output activity.
- DATA:
  - When clk_cnt reaches CLKS_PER_BIT-1: shift rx_s into shift[bit_idx] (LSB first) and reset clk_cnt.
  - After bit 7 is sampled, go to STOP.
- STOP:
  - When clk_cnt reaches CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: load o_data, set o_valid next cycle, go to IDLE. Returning to IDLE at mid-stop allows back-to-back frames with no idle gap.
  - rx_s=0: pulse o_frame_err for 1 cycle, no load, go to BREAK.
- BREAK:
  - Wait for rx_s=1, then go to IDLE.
  - This prevents a held-low line (break) from being decoded as repeated 0x00 frames.
- Latency: o_valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (+1 register) after the start-bit falling edge at the pin.
- Handshake and holding register:
  - o_valid & i_ready: clear o_valid next cycle.
  - New byte completes in the same cycle as a consume: the new byte loads and o_valid stays 1; no overrun.
  - New byte completes while o_valid=1 and i_ready=0: keep the old byte, drop the new one, pulse o_overrun for 1 cycle.
  - o_data never changes while o_valid=1 except through that simultaneous consume-and-load.
- i_start_rx=0:
  - From any state, go to IDLE on the next edge; the partial byte is discarded.
  - The holding register and handshake continue to operate.
  - Re-enabling while the line is low mid-frame may false-start. This is accepted and is caught by the glitch or stop-bit checks.
- i_ready is ignored when o_valid=0.
- o_frame_err and o_overrun are never asserted in the same cycle as a successful load of the same frame.

Test Plan (CLOCK_FREQ=10e9, BAUD_RATE=1e9, so CLKS_PER_BIT=10; i_start_rx=1, i_ready=1 unless noted):
- Send 0xFF (write command) -> exactly one o_valid pulse with o_data=0xFF, o_frame_err=0, o_busy back to 0.
- Send 0x11, 0xBB, 0xEF, 0xBE, 0xAD, 0xDE back-to-back with a 1-bit idle gap -> six o_valid beats in that order, no errors.
- Drive i_uart_rx low for 3 cycles, then high -> no o_valid, no o_frame_err, FSM returns to IDLE within 10 cycles.
- Send a frame of 0x55 with a 0 stop bit, hold the line low 40 cycles, release, then send 0x01 -> one o_frame_err pulse, no 0x00 bytes, then o_valid with 0x01.
- i_ready=0; send 0xA5 then 0x3C -> o_data stays 0xA5 and o_overrun pulses once at the second stop sample; raise i_ready -> 0xA5 accepted and o_valid falls.
- Assert rst during bit 4 of 0xC3, then send 0x7E after release -> no output for 0xC3, all outputs at reset values, then o_valid with 0x7E.
